// File: rtl/boot_pkg.sv
// Shared definitions for the boot I2C target: responder state encoding and image geometry.
package boot_pkg;

    localparam logic [6:0] BOOT_DEV_ADDR  = 7'h50;
    localparam int         BOOT_IMG_BYTES = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_IGNORE_W,
        ST_TX,
        ST_ACK_CHK,
        ST_IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and decodes bus edges and START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle-bus level so leaving reset never fabricates a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda     = r_sda_sync[SYNC_STAGES-1];
    assign sda       = w_sda;
    assign scl_rise  = w_scl & ~r_scl_prev;
    assign scl_fall  = ~w_scl & r_scl_prev;
    assign start_det = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign stop_det  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_boot_target.sv
// Read-only I2C responder serving a locally loaded boot image with pointer write and auto-increment reads.
module i2c_boot_target
    import boot_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = BOOT_DEV_ADDR,
    parameter int         MEM_DEPTH   = BOOT_IMG_BYTES,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       load_we,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       busy,
    output logic [7:0] ptr,
    output logic       rd_done
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (w_sda),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start_det(w_start),
        .stop_det (w_stop)
    );

    i2c_tgt_state_t r_state;
    logic [7:0]     r_shift;
    logic [3:0]     r_bit_cnt;
    logic           r_rw;
    logic           r_ack_phase;
    logic           r_load_pend;
    logic           r_drive_now;
    logic           r_sda_oe;
    logic           r_busy;
    logic           r_rd_done;
    logic [AW-1:0]  r_ptr;

    logic [7:0]     r_mem [MEM_DEPTH];
    logic [7:0]     r_rd_data;
    logic           w_latch_first;
    logic           w_latch_next;
    logic           w_rd_en;
    logic [AW-1:0]  w_rd_addr;
    logic [AW-1:0]  w_wr_addr;
    logic           w_bus_evt;

    assign w_bus_evt     = w_start | w_stop;
    assign w_latch_first = (r_state == ST_ADDR_ACK) && w_scl_fall && r_ack_phase && r_rw && !w_bus_evt;
    assign w_latch_next  = (r_state == ST_ACK_CHK) && w_scl_rise && !w_sda && !w_bus_evt;
    assign w_rd_en       = w_latch_first | w_latch_next;
    assign w_rd_addr     = w_latch_next ? r_ptr + AW'(1) : r_ptr;
    assign w_wr_addr     = load_addr[AW-1:0];

    // Write-first bypass so a load coinciding with the latch clk is what gets transmitted.
    always_ff @(posedge clk) begin
        if (load_we)
            r_mem[w_wr_addr] <= load_data;
        if (w_rd_en)
            r_rd_data <= (load_we && (w_wr_addr == w_rd_addr)) ? load_data : r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_load_pend <= 1'b0;
            r_drive_now <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_done   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_rd_done   <= 1'b0;
            r_load_pend <= 1'b0;
            if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= '0;
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                // First byte after the address ACK must be on SDA right as the ACK ends.
                if (r_load_pend) begin
                    if (r_drive_now) begin
                        r_shift   <= {r_rd_data[6:0], 1'b0};
                        r_sda_oe  <= ~r_rd_data[7];
                        r_bit_cnt <= 4'd1;
                    end else begin
                        r_shift   <= r_rd_data;
                        r_bit_cnt <= 4'd0;
                    end
                end
                case (r_state)
                    ST_ADDR, ST_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_ack_phase <= 1'b0;
                                if (r_state == ST_PTR) begin
                                    r_state <= ST_PTR_ACK;
                                end else if (r_shift[6:0] == DEV_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_rw    <= w_sda;
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_ack_phase <= 1'b0;
                                r_bit_cnt   <= '0;
                                if (r_state == ST_PTR_ACK) begin
                                    r_sda_oe <= 1'b0;
                                    r_ptr    <= r_shift[AW-1:0];
                                    r_state  <= ST_IGNORE_W;
                                end else if (r_rw) begin
                                    r_state     <= ST_TX;
                                    r_load_pend <= 1'b1;
                                    r_drive_now <= 1'b1;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= ST_PTR;
                                end
                            end
                        end
                    end
                    ST_TX: begin
                        if (w_scl_fall && !r_load_pend) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_ACK_CHK;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ACK_CHK: begin
                        if (w_scl_rise) begin
                            r_ptr <= r_ptr + AW'(1);
                            if (!w_sda) begin
                                r_state     <= ST_TX;
                                r_load_pend <= 1'b1;
                                r_drive_now <= 1'b0;
                            end else begin
                                r_rd_done <= 1'b1;
                                r_state   <= ST_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign rd_done = r_rd_done;
    assign ptr     = 8'(r_ptr);

endmodule

// File: tb/tb_i2c_boot_target.sv
// Directed bench: a behavioural I2C master exercises pointer writes, reads, wrap, NACK and reset cases.
module tb_i2c_boot_target;
    import boot_pkg::*;

    localparam time Q = 100ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       load_we = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       busy;
    logic [7:0] ptr;
    logic       rd_done;
    logic       w_sda;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_done_cnt = 0;
    int oe_cnt = 0;

    assign w_sda = sda_m & ~sda_oe;

    always #5ns clk = ~clk;

    i2c_boot_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_m),
        .sda_i    (w_sda),
        .sda_oe   (sda_oe),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy),
        .ptr      (ptr),
        .rd_done  (rd_done)
    );

    always @(negedge clk) begin
        if (rd_done) rd_done_cnt++;
        if (sda_oe)  oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = w_sda; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        bit_out(nack);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         rd0;
        int         oe0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_sda_oe", 32'(sda_oe), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ptr", 32'(ptr), 0);
        chk("reset_rd_done", 32'(rd_done), 0);
        rst_n = 1'b1;

        oe0 = oe_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load_we = 1'($urandom_range(0, 1));
            load_addr = 8'($urandom);
            load_data = 8'($urandom);
        end
        load_we = 1'b0;
        for (int i = 0; i < 256; i++) load(8'(i), 8'(i) ^ 8'hA5);
        chk("idle_load_no_oe", 32'(oe_cnt - oe0), 0);
        chk("idle_load_busy", 32'(busy), 0);

        // Random read from 0x10
        rd0 = rd_done_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("rr_addr_w_ack", 32'(ack), 0);
        chk("rr_busy", 32'(busy), 1);
        write_byte(8'h10, ack); chk("rr_ptr_ack", 32'(ack), 0);
        i2c_start();
        write_byte(8'hA1, ack); chk("rr_addr_r_ack", 32'(ack), 0);
        read_byte(1'b0, d); chk("rr_byte0", 32'(d), 32'hB5);
        read_byte(1'b0, d); chk("rr_byte1", 32'(d), 32'hB4);
        read_byte(1'b1, d); chk("rr_byte2", 32'(d), 32'hB7);
        i2c_stop();
        chk("rr_rd_done_cnt", 32'(rd_done_cnt - rd0), 1);
        chk("rr_ptr", 32'(ptr), 32'h13);
        chk("rr_busy_after_stop", 32'(busy), 0);

        // Pointer 0xFE, extra write byte NACKed, read across the wrap
        i2c_start();
        write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 0);
        write_byte(8'hFE, ack); chk("wr_ptr_ack", 32'(ack), 0);
        write_byte(8'h55, ack); chk("wr_extra_nack", 32'(ack), 1);
        i2c_start();
        write_byte(8'hA1, ack); chk("wr_addr_r_ack", 32'(ack), 0);
        read_byte(1'b0, d); chk("wr_byte_fe", 32'(d), 32'h5B);
        read_byte(1'b0, d); chk("wr_byte_ff", 32'(d), 32'h5A);
        read_byte(1'b1, d); chk("wr_byte_00", 32'(d), 32'hA5);
        i2c_stop();
        chk("wr_ptr_wrap", 32'(ptr), 32'h01);

        // Foreign address is ignored
        i2c_start();
        write_byte(8'hA2, ack); chk("bad_addr_nack", 32'(ack), 1);
        chk("bad_addr_busy", 32'(busy), 0);
        i2c_stop();
        chk("bad_addr_ptr", 32'(ptr), 32'h01);

        // Load racing the next-byte latch
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack);
        i2c_start();
        write_byte(8'hA1, ack); chk("race_addr_ack", 32'(ack), 0);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        chk("race_byte0", 32'(d), 32'h85);
        load(8'h21, 8'h3C);
        bit_out(1'b0);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        chk("race_load_before", 32'(d), 32'h3C);
        bit_out(1'b0);
        load(8'h22, 8'h11);
        read_byte(1'b1, d); chk("race_load_after", 32'(d), 32'h87);
        i2c_stop();
        chk("race_ptr", 32'(ptr), 32'h23);

        // Reset while driving a 0 bit
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        bit_in(b); chk("rst_bit7", 32'(b), 1);
        chk("rst_oe_before", 32'(sda_oe), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1ns;
        chk("rst_oe_async", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ptr", 32'(ptr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #Q;
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, ack); chk("rst_read_ack", 32'(ack), 0);
        read_byte(1'b1, d); chk("rst_read_byte", 32'(d), 32'hA5);
        i2c_stop();
        chk("rst_read_ptr", 32'(ptr), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
